// File: rtl/mod10_chain_ctrl.sv
// -----------------------------------------------------------------------------
// mod10_chain_ctrl
//
// Purpose:
//   Run/pause controller around a chain of NDIG cascaded BCD (mod-10) digits.
//   A start accepts a BCD terminal count (limit), the chain then advances on
//   each tick while running, and a single-cycle done pulse marks the edge on
//   which the count reaches that terminal value.
//
//   Optional build macro: MOD10_CHAIN_CTRL_AUTORELOAD_EN
//     undefined (default): reaching the terminal count parks the block in DONE
//                          with q holding the terminal value.
//     defined            : reaching the terminal count wraps q to 0 and stays
//                          in RUN, giving a free-running modulo-limit divider.
//
// Ports:
//   clk    in   single clock, all state updates on its rising edge
//   reset  in   synchronous active-high reset
//   start  in   run request; limit is sampled when the start is accepted
//   stop   in   pause request (meaningful in RUN, blocks a resume in PAUSE)
//   clear  in   return to IDLE with q = 0 from any state
//   tick   in   count-enable strobe, honoured only in RUN
//   limit  in   [4*NDIG-1:0] terminal count in BCD, digit 0 in bits [3:0]
//   q      out  [4*NDIG-1:0] current BCD count
//   state  out  [1:0] IDLE=00, RUN=01, PAUSE=10, DONE=11
//   done   out  single-cycle pulse on reaching the terminal count
//   err    out  single-cycle pulse when a start is rejected (limit digit > 9)
//
// Input precedence within one cycle: reset > clear > stop > start > tick.
// -----------------------------------------------------------------------------
module mod10_chain_ctrl #(
  parameter int NDIG = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
  input  logic              tick,
  input  logic [4*NDIG-1:0] limit,
  output logic [4*NDIG-1:0] q,
  output logic [1:0]        state,
  output logic              done,
  output logic              err
);

  localparam int W = 4 * NDIG;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t          state_reg;
  logic [W-1:0]    q_reg;
  logic [W-1:0]    lim_r;
  logic            done_reg;
  logic            err_reg;

  // Combinational BCD increment of q_reg. carry[gi] is the carry into digit
  // gi; digit 0 always receives the increment, so a full ripple across every
  // digit that sits at 9 resolves within the same cycle.
  logic [W-1:0]    q_inc;
  logic [NDIG-1:0] carry;
  logic [NDIG-1:0] lim_bad;

  assign carry[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_digit
      logic [3:0] d;
      assign d = q_reg[4*gi +: 4];

      assign q_inc[4*gi +: 4] = !carry[gi]     ? d     :
                                (d == 4'd9)    ? 4'd0  :
                                                 d + 4'd1;

      if (gi < NDIG - 1) begin : g_carry
        assign carry[gi+1] = carry[gi] & (d == 4'd9);
      end

      // A non-BCD nibble in limit makes any start in IDLE/DONE a rejected one.
      assign lim_bad[gi] = (limit[4*gi +: 4] > 4'd9);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      q_reg     <= '0;
      lim_r     <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      // done/err are pulses: low unless an event below raises them.
      done_reg <= 1'b0;
      err_reg  <= 1'b0;

      if (clear) begin
        state_reg <= IDLE;
        q_reg     <= '0;
      end else begin
        case (state_reg)
          // DONE accepts a start exactly like IDLE; stop and tick are
          // meaningless in both. A rejected start changes nothing but err.
          IDLE, DONE: begin
            if (start) begin
              if (|lim_bad) begin
                err_reg <= 1'b1;
              end else begin
                lim_r <= limit;
                q_reg <= '0;
                if (limit == '0) begin
                  // Terminal count of zero is reached immediately.
                  state_reg <= DONE;
                  done_reg  <= 1'b1;
                end else begin
                  state_reg <= RUN;
                end
              end
            end
          end

          RUN: begin
            if (stop) begin
              // Pause wins; a tick in the same cycle is dropped.
              state_reg <= PAUSE;
            end else if (tick) begin
              if (q_inc == lim_r) begin
                done_reg <= 1'b1;
`ifdef MOD10_CHAIN_CTRL_AUTORELOAD_EN
                q_reg    <= '0;
`else
                q_reg     <= q_inc;
                state_reg <= DONE;
`endif
              end else begin
                q_reg <= q_inc;
              end
            end
          end

          PAUSE: begin
            // Resume keeps the previously latched terminal count.
            if (start && !stop) begin
              state_reg <= RUN;
            end
          end

          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  assign q     = q_reg;
  assign state = state_reg;
  assign done  = done_reg;
  assign err   = err_reg;

endmodule

// File: tb/tb_mod10_chain_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mod10_chain_ctrl
//
// Scoreboard bench for mod10_chain_ctrl (NDIG = 3). Each stimulus cycle is
// applied on the falling edge; a behavioural model working on plain integer
// counts predicts the outputs after the following rising edge and pushes them
// into a queue. An independent monitor pops one entry after every rising edge
// and compares it with q/state/done/err.
// -----------------------------------------------------------------------------
module tb_mod10_chain_ctrl;

  localparam int NDIG = 3;
  localparam int W    = 4 * NDIG;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         clear = 1'b0;
  logic         tick = 1'b0;
  logic [W-1:0] limit = '0;
  logic [W-1:0] q;
  logic [1:0]   state;
  logic         done;
  logic         err;

  mod10_chain_ctrl #(.NDIG(NDIG)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .stop  (stop),
    .clear (clear),
    .tick  (tick),
    .limit (limit),
    .q     (q),
    .state (state),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [1:0]   st;
    logic         dn;
    logic         er;
    string        tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   armed  = 1'b0;

  // Reference model state: counts are ordinary integers.
  int         m_q   = 0;
  int         m_lim = 0;
  logic [1:0] m_st  = S_IDLE;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int           x;
    r = '0;
    x = v;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit bcd_ok(input logic [W-1:0] v);
    for (int i = 0; i < NDIG; i++) begin
      if (((v >> (4*i)) & 'hF) > 9) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int from_bcd(input logic [W-1:0] v);
    int r;
    int scale;
    r = 0;
    scale = 1;
    for (int i = 0; i < NDIG; i++) begin
      r = r + int'((v >> (4*i)) & 'hF) * scale;
      scale = scale * 10;
    end
    return r;
  endfunction

  // One clock of stimulus: drive inputs, advance the model, queue expectation.
  task automatic cyc(input logic r, input logic c, input logic s,
                     input logic p, input logic t, input logic [W-1:0] lim,
                     input string tag);
    exp_t e;
    bit   dn;
    bit   er;
    @(negedge clk);
    reset = r;
    clear = c;
    start = s;
    stop  = p;
    tick  = t;
    limit = lim;

    dn = 1'b0;
    er = 1'b0;
    if (r) begin
      m_st = S_IDLE; m_q = 0; m_lim = 0;
    end else if (c) begin
      m_st = S_IDLE; m_q = 0;
    end else if (m_st == S_IDLE || m_st == S_DONE) begin
      if (s) begin
        if (!bcd_ok(lim)) begin
          er = 1'b1;
        end else begin
          m_lim = from_bcd(lim);
          m_q   = 0;
          if (m_lim == 0) begin
            m_st = S_DONE; dn = 1'b1;
          end else begin
            m_st = S_RUN;
          end
        end
      end
    end else if (m_st == S_RUN) begin
      if (p) begin
        m_st = S_PAUSE;
      end else if (t) begin
        m_q = m_q + 1;
        if (m_q == m_lim) begin
          dn = 1'b1;
`ifdef MOD10_CHAIN_CTRL_AUTORELOAD_EN
          m_q = 0;
`else
          m_st = S_DONE;
`endif
        end
      end
    end else begin
      if (s && !p) m_st = S_RUN;
    end

    e.q   = to_bcd(m_q);
    e.st  = m_st;
    e.dn  = dn;
    e.er  = er;
    e.tag = tag;
    exp_q.push_back(e);
    armed = 1'b1;
  endtask

  // Monitor: one comparison per rising edge once stimulus has begun.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (armed) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty at %0t: no expectation queued", $time);
        end else begin
          e = exp_q.pop_front();
          if (q !== e.q || state !== e.st || done !== e.dn || err !== e.er) begin
            errors++;
            $display("FAIL %s: got q=%h state=%b done=%b err=%b, want q=%h state=%b done=%b err=%b",
                     e.tag, q, state, done, err, e.q, e.st, e.dn, e.er);
          end else begin
            $display("ok   %s: q=%h state=%b done=%b err=%b", e.tag, q, state, done, err);
          end
        end
      end
    end
  end

  initial begin
    // Reset for one cycle, then count to 025.
    cyc(1, 0, 0, 0, 0, 12'h000, "reset");
    cyc(0, 0, 1, 0, 0, 12'h025, "start_025");
    for (int i = 0; i < 25; i++) cyc(0, 0, 0, 0, 1, 12'h999, "tick_to_025");
    cyc(0, 0, 0, 0, 1, 12'h000, "done_hold_tick");
    cyc(0, 0, 0, 1, 0, 12'h000, "done_hold_stop");

    // Two-digit carry 099 -> 100.
    cyc(0, 0, 1, 0, 0, 12'h100, "start_100");
    for (int i = 0; i < 100; i++) cyc(0, 0, 0, 0, 1, 12'h000, "tick_to_100");

    // Pause at 007 with a simultaneous tick, ignored ticks, resume.
    cyc(0, 1, 0, 0, 0, 12'h000, "clear");
    cyc(0, 0, 1, 0, 0, 12'h050, "start_050");
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 1, 12'h000, "tick_to_007");
    cyc(0, 0, 0, 1, 1, 12'h000, "stop_with_tick");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 12'h000, "pause_tick");
    cyc(0, 0, 1, 0, 0, 12'h003, "resume_no_resample");
    cyc(0, 0, 0, 0, 1, 12'h000, "tick_to_008");

    // Rejected start, then zero limit.
    cyc(0, 1, 0, 0, 0, 12'h000, "clear");
    cyc(0, 0, 1, 0, 0, 12'h0A3, "start_bad_0A3");
    cyc(0, 0, 0, 0, 0, 12'h0A3, "err_gone");
    cyc(0, 0, 1, 0, 0, 12'h000, "start_000");
    cyc(0, 0, 0, 0, 0, 12'h000, "done_gone");

    // Reset mid-count at 013, then clear mid-count at 013.
    cyc(0, 0, 1, 0, 0, 12'h014, "start_014");
    for (int i = 0; i < 13; i++) cyc(0, 0, 0, 0, 1, 12'h000, "tick_to_013");
    cyc(1, 0, 0, 0, 1, 12'h000, "reset_at_013");
    cyc(0, 0, 1, 0, 0, 12'h014, "start_014");
    for (int i = 0; i < 13; i++) cyc(0, 0, 0, 0, 1, 12'h000, "tick_to_013");
    cyc(0, 1, 0, 0, 1, 12'h000, "clear_at_013");

    // Limit 003 with nine ticks (divider behaviour in the autoreload build).
    cyc(0, 0, 1, 0, 0, 12'h003, "start_003");
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 1, 12'h000, "tick_lim_003");

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      logic [W-1:0] lim;
      if ($urandom_range(0, 7) == 0) lim = W'($urandom);
      else lim = {4'h0, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 49) == 0,
          $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 1) == 1, lim, "random");
    end

    cyc(0, 0, 0, 0, 0, 12'h000, "idle_tail");
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod10_chain_ctrl.md
MOD10_CHAIN_CTRL -- requirements
Module: mod10_chain_ctrl

Interface
REQ-001 The block SHALL have parameter NDIG, default 3, giving the number of cascaded mod-10 (BCD) digits; the legal range is 1..4.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: a run request; limit is sampled when start is accepted.
REQ-005 The block SHALL have port stop, input, 1 bit: a pause request.
REQ-006 The block SHALL have port clear, input, 1 bit: returns the block to IDLE and zeroes q.
REQ-007 The block SHALL have port tick, input, 1 bit: count-enable strobe, honoured only in RUN.
REQ-008 The block SHALL have port limit, input, 4*NDIG bits: terminal count in BCD, least-significant digit in bits [3:0].
REQ-009 The block SHALL have port q, output, 4*NDIG bits: current BCD count.
REQ-010 The block SHALL have port state, output, 2 bits: IDLE=00, RUN=01, PAUSE=10, DONE=11.
REQ-011 The block SHALL have port done, output, 1 bit: a single-cycle pulse when the terminal count is reached.
REQ-012 The block SHALL have port err, output, 1 bit: a single-cycle pulse when a start is rejected.

Function
REQ-013 Each digit SHALL count 0..9; on a tick with the digit at 9, the digit SHALL wrap to 0 and carry into the next digit in the same cycle.
REQ-014 q SHALL change on the clock edge that samples tick=1 in RUN, i.e. with one-cycle latency.
REQ-015 Each accepted start SHALL latch limit into an internal register lim_r; later changes to limit SHALL be ignored until the next accepted start.
REQ-016 In IDLE, start with all limit digits ≤9 and limit≠0 SHALL move the state to RUN with q=0.
REQ-017 In IDLE, start with limit=0 SHALL move the state to DONE and pulse done in the next cycle.
REQ-018 In IDLE, start with any limit digit >9 SHALL leave the state in IDLE and pulse err for one cycle.
REQ-019 In RUN, a tick that makes the next q equal lim_r SHALL update q and pulse done; the state transition on that edge is set by REQ-031.
REQ-020 In RUN, stop SHALL move the state to PAUSE with q held; a tick in the same cycle as stop SHALL be discarded.
REQ-021 In PAUSE, start SHALL return the state to RUN without re-sampling limit; ticks SHALL be ignored while in PAUSE.
REQ-022 In DONE, q SHALL hold lim_r and ticks and stop SHALL be ignored; start SHALL behave as in IDLE (q cleared, limit re-sampled).
REQ-023 clear SHALL force the state to IDLE and q to 0 in any state.
REQ-024 Input precedence within one cycle SHALL be reset > clear > stop > start > tick.
REQ-025 done and err SHALL never assert in the same cycle.

Reset
REQ-026 On a clock edge with reset=1, the block SHALL set state=IDLE, q=0, lim_r=0, done=0 and err=0.
REQ-027 Reset asserted mid-count SHALL abort the count, and no done SHALL be generated by that edge.
REQ-028 The block SHALL contain no asynchronous reset paths.

Configuration
REQ-029 The block SHALL support the macro MOD10_CHAIN_CTRL_AUTORELOAD_EN.
REQ-030 With MOD10_CHAIN_CTRL_AUTORELOAD_EN defined, reaching the terminal count SHALL pulse done, set q=0 on the same edge and keep the state in RUN (free-running modulo-(lim_r) divider).
REQ-031 Without MOD10_CHAIN_CTRL_AUTORELOAD_EN, reaching the terminal count SHALL move the state to DONE with q=lim_r held, per REQ-022.

Verification
REQ-032 The bench SHALL cover: reset=1 for 1 cycle, then start with limit=12'h025 and 25 consecutive ticks -> q steps 000..025, done pulses once, and the state goes to DONE (macro undefined).
REQ-033 The bench SHALL cover: limit=12'h100, ticks from q=099 -> the next q is 100 (carry across two digits in one cycle), done pulses, and the state goes to DONE.
REQ-034 The bench SHALL cover: in RUN at q=007, stop and tick in the same cycle -> state=PAUSE and q=007; three further ticks leave q=007; start -> RUN, and the next tick gives q=008.
REQ-035 The bench SHALL cover: start with limit=12'h0A3 -> err pulses for 1 cycle and state stays IDLE; start with limit=12'h000 -> state goes to DONE and done pulses.
REQ-036 The bench SHALL cover: reset or clear asserted at q=013 in RUN -> on the next edge q=000, state=IDLE, and no done pulse.
REQ-037 The bench SHALL cover: with MOD10_CHAIN_CTRL_AUTORELOAD_EN defined and limit=12'h003, nine ticks -> q sequence 1,2,0,1,2,0,1,2,0, done pulses 3 times, and state stays RUN.
